// File: rtl/rip_uart_tx_fifo.sv
// UART transmitter that pops one word per frame from a synchronous FIFO read port
// and serialises it LSB first with optional parity and one or two stop bits.
module rip_uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic                  fifo_r_empty,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        clk_cnt_q;
    logic [CNT_W-1:0]        clk_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic                    stop_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    parity_q;
    logic                    tx_q;
    logic                    busy_q;
    logic                    tx_done_q;
    logic                    bit_end;
    logic                    last_stop;
    logic                    launch;

    assign bit_end   = (clk_cnt_q == CNT_LAST);
    assign clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    assign last_stop = (state_q == S_STOP) && (stop_cnt_q == STOP_LAST) && bit_end;

    // rst_n gating keeps the pop strobe quiet while reset holds the FSM in IDLE.
    assign launch    = rst_n && enable && !fifo_r_empty && ((state_q == S_IDLE) || last_stop);
    assign fifo_r_en = launch;

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            clk_cnt_q <= clk_cnt_d;
            if (launch) begin
                shift_q   <= fifo_r_data;
                parity_q  <= (^fifo_r_data) ^ (PARITY_ODD != 0);
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                clk_cnt_q <= '0;
                state_q   <= S_START;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        clk_cnt_q <= '0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= '0;
                            state_q   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            if (bit_cnt_q == BIT_LAST) begin
                                if (PARITY_EN != 0) begin
                                    tx_q    <= parity_q;
                                    state_q <= S_PARITY;
                                end else begin
                                    tx_q       <= 1'b1;
                                    stop_cnt_q <= 1'b0;
                                    state_q    <= S_STOP;
                                end
                            end else begin
                                tx_q      <= shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 1'b0;
                            state_q    <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // A relaunch out of the final stop cycle is taken by the launch branch.
                        if (bit_end) begin
                            if (stop_cnt_q == STOP_LAST) begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                stop_cnt_q <= 1'b1;
                            end
                        end else if ((stop_cnt_q == STOP_LAST) && (clk_cnt_q == CNT_PRE)) begin
                            tx_done_q <= 1'b1;
                        end
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rip_uart_tx_fifo.sv
// Bench for rip_uart_tx_fifo: three parameter variants driven in lockstep from FIFO
// queues, checked every cycle against a frame-timeline model of the serial line.
module tb_rip_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int NI  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   en;
    logic [NI-1:0]   empty;
    logic [7:0]      rdata [NI];
    wire  [NI-1:0]   ren;
    wire  [NI-1:0]   tx;
    wire  [NI-1:0]   busy;
    wire  [NI-1:0]   done;

    always #5 clk = ~clk;

    // inst0: no parity, 1 stop; inst1: even parity, 1 stop; inst2: odd parity, 2 stops
    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            rip_uart_tx_fifo #(
                .DATA_WIDTH  (8),
                .CLKS_PER_BIT(CPB),
                .PARITY_EN   ((gi >= 1) ? 1 : 0),
                .PARITY_ODD  ((gi == 2) ? 1 : 0),
                .STOP_BITS   ((gi == 2) ? 2 : 1)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .enable      (en[gi]),
                .fifo_r_data (rdata[gi]),
                .fifo_r_empty(empty[gi]),
                .fifo_r_en   (ren[gi]),
                .tx          (tx[gi]),
                .busy        (busy[gi]),
                .tx_done     (done[gi])
            );
        end
    endgenerate

    logic [7:0]    fq [NI][$];
    logic [1:0]    eq [NI][$];
    logic [NI-1:0] en_nx;
    logic          rst_nx;
    logic [NI-1:0] pend;
    logic [NI-1:0] e_tx, e_busy, e_done, e_ren;
    int            obs_pops [NI];
    int            first_pop [NI];
    int            last_pop [NI];
    int            last_done [NI];
    int            cyc;
    int            total;
    int            bad;

    function automatic int par_en(int i);
        return (i >= 1) ? 1 : 0;
    endfunction

    function automatic int stops(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // Append one whole frame (start, data LSB first, parity, stops) as per-cycle line values.
    task automatic push_frame(input int i, input logic [7:0] w);
        logic seq[$];
        seq.push_back(1'b0);
        for (int k = 0; k < 8; k++) seq.push_back(w[k]);
        if (par_en(i) != 0) seq.push_back((^w) ^ (i == 2));
        for (int s = 0; s < stops(i); s++) seq.push_back(1'b1);
        for (int j = 0; j < seq.size(); j++)
            for (int c = 0; c < CPB; c++)
                eq[i].push_back({seq[j], (j == seq.size() - 1) && (c == CPB - 1)});
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NI; i++) begin
            obs_pops[i]  = 0;
            first_pop[i] = -1;
            last_pop[i]  = -1;
            last_done[i] = -1;
        end
    endtask

    // One clock: apply model pops and inputs away from the edge, then sample and advance the model.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            pend[i] = 1'b0;
        end
        rst_n = rst_nx;
        en    = en_nx;
        for (int i = 0; i < NI; i++) begin
            if (fq[i].size() > 0) begin
                empty[i] = 1'b0;
                rdata[i] = fq[i][0];
            end else begin
                empty[i] = 1'b1;
                rdata[i] = 8'($urandom);
            end
        end
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                eq[i].delete();
                e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_ren[i] = 1'b0;
            end else begin
                e_ren[i] = en[i] && (fq[i].size() > 0) && (eq[i].size() <= 1);
                if (eq[i].size() > 0) begin
                    e_tx[i]   = eq[i][0][1];
                    e_done[i] = eq[i][0][0];
                    e_busy[i] = 1'b1;
                    void'(eq[i].pop_front());
                end else begin
                    e_tx[i] = 1'b1; e_done[i] = 1'b0; e_busy[i] = 1'b0;
                end
                if (e_ren[i]) begin
                    push_frame(i, fq[i][0]);
                    pend[i] = 1'b1;
                end
            end
            if (ren[i] === 1'b1) begin
                obs_pops[i]++;
                if (first_pop[i] < 0) first_pop[i] = cyc;
                last_pop[i] = cyc;
            end
            if (done[i] === 1'b1) last_done[i] = cyc;
        end
    endtask

    task automatic test_reset();
        rst_nx = 1'b0;
        en_nx  = '1;
        for (int i = 0; i < NI; i++) fq[i].push_back(8'h11);
        for (int n = 0; n < 8; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== 4'b1000) begin
                    bad++;
                    $display("FAIL reset inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=1000",
                             i, cyc, {tx[i], busy[i], done[i], ren[i]});
                end
            end
        end
        for (int i = 0; i < NI; i++) fq[i].delete();
    endtask

    task automatic test_empty();
        rst_nx = 1'b1;
        en_nx  = '1;
        clear_obs();
        for (int n = 0; n < 30; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL empty inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (obs_pops[i] !== 0) begin
                bad++;
                $display("FAIL empty_pops inst%0d got=%0d exp=0", i, obs_pops[i]);
            end
        end
    endtask

    task automatic test_single();
        clear_obs();
        for (int i = 0; i < NI; i++) fq[i].push_back(8'hA5);
        for (int n = 0; n < 60; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL single inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
        total++;
        if (obs_pops[0] !== 1) begin
            bad++;
            $display("FAIL single_pops got=%0d exp=1", obs_pops[0]);
        end
        total++;
        if (last_done[0] - last_pop[0] !== 40) begin
            bad++;
            $display("FAIL single_len got=%0d exp=40", last_done[0] - last_pop[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        for (int i = 0; i < NI; i++) begin
            fq[i].push_back(8'h00);
            fq[i].push_back(8'hFF);
        end
        for (int n = 0; n < 110; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL b2b inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
        total++;
        if (obs_pops[0] !== 2) begin
            bad++;
            $display("FAIL b2b_pops got=%0d exp=2", obs_pops[0]);
        end
        total++;
        if (last_pop[0] - first_pop[0] !== 40) begin
            bad++;
            $display("FAIL b2b_pop_gap got=%0d exp=40", last_pop[0] - first_pop[0]);
        end
        total++;
        if (last_done[0] - first_pop[0] !== 80) begin
            bad++;
            $display("FAIL b2b_total got=%0d exp=80", last_done[0] - first_pop[0]);
        end
    endtask

    task automatic test_parity();
        logic par_bit [NI];
        clear_obs();
        for (int i = 0; i < NI; i++) begin
            fq[i].push_back(8'h07);
            par_bit[i] = 1'bx;
        end
        for (int n = 0; n < 70; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                if (first_pop[i] >= 0 && cyc == first_pop[i] + 38) par_bit[i] = tx[i];
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL parity inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
        total++;
        if (par_bit[1] !== 1'b1) begin
            bad++;
            $display("FAIL parity_even_bit got=%b exp=1", par_bit[1]);
        end
        total++;
        if (par_bit[2] !== 1'b0) begin
            bad++;
            $display("FAIL parity_odd_bit got=%b exp=0", par_bit[2]);
        end
        total++;
        if (last_done[1] - last_pop[1] !== 44) begin
            bad++;
            $display("FAIL parity_len got=%0d exp=44", last_done[1] - last_pop[1]);
        end
        total++;
        if (last_done[2] - last_pop[2] !== 48) begin
            bad++;
            $display("FAIL parity_stop2_len got=%0d exp=48", last_done[2] - last_pop[2]);
        end
    endtask

    task automatic test_enable_gating();
        clear_obs();
        en_nx = '0;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 3; k++) fq[i].push_back(8'($urandom));
        for (int n = 0; n < 100; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], ren[i]} !== 3'b100) begin
                    bad++;
                    $display("FAIL enable_off inst%0d cyc=%0d {tx,busy,ren} got=%b exp=100",
                             i, cyc, {tx[i], busy[i], ren[i]});
                end
            end
        end
        en_nx = '1;
        for (int n = 0; n < 5 && obs_pops[0] == 0; n++) step();
        total++;
        if (obs_pops[0] == 0) begin
            bad++;
            $display("FAIL enable_launch_timeout got=0 pops exp=1");
        end
        for (int n = 0; n < 70; n++) begin
            if (n == 10) en_nx = '0;
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL enable_drop inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            total++;
            if (obs_pops[i] !== 1) begin
                bad++;
                $display("FAIL enable_pops inst%0d got=%0d exp=1", i, obs_pops[i]);
            end
            fq[i].delete();
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        for (int i = 0; i < NI; i++) begin
            fq[i].push_back(8'h3C);
            fq[i].push_back(8'h5A);
        end
        en_nx = '1;
        for (int n = 0; n < 5 && obs_pops[0] == 0; n++) step();
        total++;
        if (obs_pops[0] == 0) begin
            bad++;
            $display("FAIL rstmid_launch_timeout got=0 pops exp=1");
        end
        for (int n = 0; n < 15; n++) step();
        rst_nx = 1'b0;
        step();
        total++;
        if (tx !== '1 || busy !== '0) begin
            bad++;
            $display("FAIL rstmid_async {tx,busy} got=%b_%b exp=111_000", tx, busy);
        end
        step();
        step();
        rst_nx = 1'b1;
        clear_obs();
        for (int n = 0; n < 70; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL rstmid inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
        total++;
        if (obs_pops[0] !== 1) begin
            bad++;
            $display("FAIL rstmid_pops got=%0d exp=1", obs_pops[0]);
        end
    endtask

    task automatic test_random();
        clear_obs();
        en_nx = '1;
        for (int n = 0; n < 900; n++) begin
            if (n < 700) begin
                if ($urandom_range(0, 15) == 0) en_nx = 3'($urandom);
                for (int i = 0; i < NI; i++)
                    if (fq[i].size() < 4 && $urandom_range(0, 29) == 0) fq[i].push_back(8'($urandom));
            end else begin
                en_nx = '1;
            end
            step();
            for (int i = 0; i < NI; i++) begin
                total++;
                if ({tx[i], busy[i], done[i], ren[i]} !== {e_tx[i], e_busy[i], e_done[i], e_ren[i]}) begin
                    bad++;
                    $display("FAIL random inst%0d cyc=%0d {tx,busy,done,ren} got=%b exp=%b", i, cyc,
                             {tx[i], busy[i], done[i], ren[i]}, {e_tx[i], e_busy[i], e_done[i], e_ren[i]});
                end
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        rst_nx = 1'b0;
        en     = '0;
        en_nx  = '0;
        empty  = '1;
        pend   = '0;
        for (int i = 0; i < NI; i++) rdata[i] = 8'h00;
        clear_obs();

        test_reset();
        test_empty();
        test_single();
        test_back_to_back();
        test_parity();
        test_enable_gating();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
